// File: rtl/karatsuba_pkg.sv
// Shared definitions for the sequential Karatsuba multiplier: FSM encoding and width helpers.
// Latency: none (package only).
// Backpressure: not applicable.
package karatsuba_pkg;

  // FSM encoding, 3 bits wide, kept as plain constants so older tools can read it
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_MUL_LL  = 3'd1;
  localparam logic [2:0] ST_MUL_HH  = 3'd2;
  localparam logic [2:0] ST_MUL_MID = 3'd3;
  localparam logic [2:0] ST_COMBINE = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  // Widest operand abs_mag can handle
  localparam int MAG_MAX_W = 64;

  function automatic int half_w(input int w);
    return w / 2;
  endfunction

  // Operand width of the shared core: one extra bit holds the carry of xl+xh
  function automatic int core_w(input int w);
    return (w / 2) + 1;
  endfunction

  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction

  function automatic int inter_w(input int w);
    return (2 * w) + 2;
  endfunction

  // Magnitude of a width-bit value. In signed mode the most negative value
  // maps to 2^(width-1), which still fits in width bits as unsigned.
  function automatic logic [MAG_MAX_W-1:0] abs_mag(input logic [MAG_MAX_W-1:0] value,
                                                   input int width,
                                                   input logic signed_mode);
    logic [MAG_MAX_W-1:0] mask;
    mask = (width >= MAG_MAX_W) ? '1 : ((64'd1 << width) - 64'd1);
    if (signed_mode && value[width-1])
      abs_mag = (~value + 64'd1) & mask;
    else
      abs_mag = value & mask;
  endfunction

endpackage

// File: rtl/karatsuba_mul_core.sv
// Unsigned N x N -> 2N combinational multiplier, shared by all three partial products.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the owning FSM decides when the product is captured.
module karatsuba_mul_core #(
  parameter int N = 5
) (
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] p
);

  assign p = (2*N)'(a) * (2*N)'(b);

endmodule

// File: rtl/karatsuba_seq.sv
// One-level Karatsuba multiplier with signed/unsigned mode; three sub-products run serially on one core.
// Latency: result valid 4 edges after the accepting edge; one result per 6 cycles at full rate.
// Backpressure: result held in DONE until out_ready; in_ready is low in every state but IDLE.
module karatsuba_seq
  import karatsuba_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     X,
  input  logic [WIDTH-1:0]     Y,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   Z,
  output logic                 busy
);

  localparam int H  = half_w(WIDTH);
  localparam int N  = core_w(WIDTH);
  localparam int PW = prod_w(WIDTH);

  if ((WIDTH % 2) != 0 || WIDTH < 4 || WIDTH > MAG_MAX_W) begin : g_bad_width
    $error("karatsuba_seq: WIDTH must be even, >= 4 and <= 64");
  end

  logic [2:0]       state;
  logic [WIDTH-1:0] x_mag;
  logic [WIDTH-1:0] y_mag;
  logic             neg;
  logic [2*N-1:0]   z0;
  logic [2*N-1:0]   z1;
  logic [2*N-1:0]   z2;

  logic [N-1:0]     core_a;
  logic [N-1:0]     core_b;
  logic [2*N-1:0]   core_p;

  logic [PW-1:0]    z0_e;
  logic [PW-1:0]    z1_e;
  logic [PW-1:0]    z2_e;
  logic [PW-1:0]    p_trunc;

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);

  // Operand mux: route the half-words (or their sums) for the current MUL state into the shared core
  always_comb begin
    core_a = '0;
    core_b = '0;
    case (state)
      ST_MUL_LL: begin
        core_a = N'(x_mag[H-1:0]);
        core_b = N'(y_mag[H-1:0]);
      end
      ST_MUL_HH: begin
        core_a = N'(x_mag[WIDTH-1:H]);
        core_b = N'(y_mag[WIDTH-1:H]);
      end
      ST_MUL_MID: begin
        core_a = N'(x_mag[H-1:0]) + N'(x_mag[WIDTH-1:H]);
        core_b = N'(y_mag[H-1:0]) + N'(y_mag[WIDTH-1:H]);
      end
      default: begin
        core_a = '0;
        core_b = '0;
      end
    endcase
  end

  karatsuba_mul_core #(.N(N)) u_core (
    .a (core_a),
    .b (core_b),
    .p (core_p)
  );

  // Recombine the three sub-products. Evaluated directly modulo 2^(2*WIDTH):
  // the two extra headroom bits of the wider intermediate would be discarded
  // by the final truncation anyway, so the kept bits are identical.
  always_comb begin
    z0_e    = PW'(z0);
    z1_e    = PW'(z1);
    z2_e    = PW'(z2);
    p_trunc = (z2_e << WIDTH) + ((z1_e - z2_e - z0_e) << H) + z0_e;
  end

  // Control FSM plus operand, partial-product and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      x_mag <= '0;
      y_mag <= '0;
      neg   <= 1'b0;
      z0    <= '0;
      z1    <= '0;
      z2    <= '0;
      Z     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            x_mag <= WIDTH'(abs_mag(MAG_MAX_W'(X), WIDTH, signed_mode));
            y_mag <= WIDTH'(abs_mag(MAG_MAX_W'(Y), WIDTH, signed_mode));
            neg   <= signed_mode & (X[WIDTH-1] ^ Y[WIDTH-1]);
            state <= ST_MUL_LL;
          end
        end
        ST_MUL_LL: begin
          z0    <= core_p;
          state <= ST_MUL_HH;
        end
        ST_MUL_HH: begin
          z2    <= core_p;
          state <= ST_MUL_MID;
        end
        ST_MUL_MID: begin
          z1    <= core_p;
          state <= ST_COMBINE;
        end
        ST_COMBINE: begin
          // Negating zero yields zero, so 0 * negative never produces a stray sign
          Z     <= neg ? (-p_trunc) : p_trunc;
          state <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_karatsuba_seq.sv
// Directed and random checks of karatsuba_seq at WIDTH=8 and WIDTH=16.
// Latency: expects out_valid 4 edges after the accepting edge.
// Backpressure: holds out_ready low to confirm the result is held and new operands ignored.
module tb_karatsuba_seq;
  import karatsuba_pkg::*;

  logic        clk;
  logic        rst_n;

  logic        iv8, ir8, sm8, ov8, or8, busy8;
  logic [7:0]  x8, y8;
  logic [15:0] z8;

  logic        iv16, ir16, sm16, ov16, or16, busy16;
  logic [15:0] x16, y16;
  logic [31:0] z16;

  int checks;
  int errors;

  karatsuba_seq #(.WIDTH(8)) dut8 (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (iv8),
    .in_ready    (ir8),
    .signed_mode (sm8),
    .X           (x8),
    .Y           (y8),
    .out_valid   (ov8),
    .out_ready   (or8),
    .Z           (z8),
    .busy        (busy8)
  );

  karatsuba_seq #(.WIDTH(16)) dut16 (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (iv16),
    .in_ready    (ir16),
    .signed_mode (sm16),
    .X           (x16),
    .Y           (y16),
    .out_valid   (ov16),
    .out_ready   (or16),
    .Z           (z16),
    .busy        (busy16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present operands for one edge, then wait (bounded) for out_valid.
  // lat = edges after acceptance until out_valid, 99 on timeout.
  task automatic launch8(input logic [7:0] x, input logic [7:0] y, input logic sm,
                         output int lat, output bit ir_low);
    iv8 = 1'b1; x8 = x; y8 = y; sm8 = sm;
    @(posedge clk); #1;
    iv8 = 1'b0; x8 = ~x; y8 = ~y; sm8 = ~sm;
    lat = 99;
    ir_low = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      if (ir8 !== 1'b0) ir_low = 1'b0;
      @(posedge clk); #1;
      if (ov8 === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic pop8();
    or8 = 1'b1;
    @(posedge clk); #1;
    or8 = 1'b0;
  endtask

  task automatic launch16(input logic [15:0] x, input logic [15:0] y, input logic sm,
                          output int lat);
    iv16 = 1'b1; x16 = x; y16 = y; sm16 = sm;
    @(posedge clk); #1;
    iv16 = 1'b0; x16 = ~x; y16 = ~y; sm16 = ~sm;
    lat = 99;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (ov16 === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic pop16();
    or16 = 1'b1;
    @(posedge clk); #1;
    or16 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ir8, ov8, busy8} !== 3'b100) begin
      errors++;
      $display("FAIL reset_ctrl8: got in_ready/out_valid/busy=%b required 100", {ir8, ov8, busy8});
    end
    checks++;
    if (z8 !== 16'h0000) begin
      errors++;
      $display("FAIL reset_z8: got %h required 0000", z8);
    end
    checks++;
    if ({ir16, ov16, busy16} !== 3'b100 || z16 !== 32'h0) begin
      errors++;
      $display("FAIL reset_16: got ctrl=%b z=%h required ctrl=100 z=00000000", {ir16, ov16, busy16}, z16);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned8();
    int lat;
    bit ir_low;
    logic [7:0]  xs [3] = '{8'h11, 8'hFF, 8'h00};
    logic [7:0]  ys [3] = '{8'h11, 8'hFF, 8'hAB};
    logic [15:0] zs [3] = '{16'h0121, 16'hFE01, 16'h0000};
    for (int i = 0; i < 3; i++) begin
      launch8(xs[i], ys[i], 1'b0, lat, ir_low);
      checks++;
      if (z8 !== zs[i]) begin
        errors++;
        $display("FAIL unsigned8_z[%0d]: got %h required %h", i, z8, zs[i]);
      end
      checks++;
      if (lat != 4) begin
        errors++;
        $display("FAIL unsigned8_latency[%0d]: got %0d required 4", i, lat);
      end
      checks++;
      if (!ir_low) begin
        errors++;
        $display("FAIL unsigned8_in_ready[%0d]: got high while busy required low", i);
      end
      pop8();
      checks++;
      if ({ir8, ov8} !== 2'b10) begin
        errors++;
        $display("FAIL unsigned8_release[%0d]: got in_ready/out_valid=%b required 10", i, {ir8, ov8});
      end
    end
  endtask

  task automatic test_signed8();
    int lat;
    bit ir_low;
    logic [7:0]  xs [4] = '{8'h80, 8'hFF, 8'h00, 8'h7F};
    logic [7:0]  ys [4] = '{8'h80, 8'h05, 8'hFD, 8'h81};
    logic [15:0] zs [4] = '{16'h4000, 16'hFFFB, 16'h0000, 16'hC0FF};
    for (int i = 0; i < 4; i++) begin
      launch8(xs[i], ys[i], 1'b1, lat, ir_low);
      checks++;
      if (z8 !== zs[i] || lat != 4) begin
        errors++;
        $display("FAIL signed8[%0d]: got z=%h lat=%0d required z=%h lat=4", i, z8, lat, zs[i]);
      end
      pop8();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    bit ir_low;
    launch8(8'h0C, 8'h0D, 1'b0, lat, ir_low);
    checks++;
    if (lat != 4 || z8 !== 16'h009C) begin
      errors++;
      $display("FAIL bp_result: got z=%h lat=%0d required z=009c lat=4", z8, lat);
    end
    for (int i = 0; i < 10; i++) begin
      iv8 = i[0];
      x8  = 8'h55 + 8'(i);
      y8  = 8'h33;
      @(posedge clk); #1;
      checks++;
      if ({ov8, ir8} !== 2'b10 || z8 !== 16'h009C) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got out_valid/in_ready=%b z=%h required 10 z=009c", i, {ov8, ir8}, z8);
      end
    end
    iv8 = 1'b0;
    pop8();
    checks++;
    if ({ov8, ir8} !== 2'b01) begin
      errors++;
      $display("FAIL bp_release: got out_valid/in_ready=%b required 01", {ov8, ir8});
    end
    @(posedge clk); #1;
    checks++;
    if (busy8 !== 1'b0) begin
      errors++;
      $display("FAIL bp_no_ghost_op: got busy=%b required 0", busy8);
    end
  endtask

  task automatic test_reset_mid_op();
    int lat;
    bit ir_low;
    bit saw_valid;
    iv8 = 1'b1; x8 = 8'h0F; y8 = 8'h0F; sm8 = 1'b0;
    @(posedge clk); #1;
    iv8 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (dut8.state !== ST_MUL_MID) begin
      errors++;
      $display("FAIL midrst_in_mid: got state=%0d required %0d", dut8.state, ST_MUL_MID);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++;
    if (dut8.state !== ST_IDLE || {ov8, ir8} !== 2'b01 || z8 !== 16'h0000) begin
      errors++;
      $display("FAIL midrst_state: got state=%0d ov/ir=%b z=%h required state=0 ov/ir=01 z=0000",
               dut8.state, {ov8, ir8}, z8);
    end
    saw_valid = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ov8 !== 1'b0) saw_valid = 1'b1;
    end
    checks++;
    if (saw_valid) begin
      errors++;
      $display("FAIL midrst_discard: got out_valid=1 after reset required 0");
    end
    launch8(8'h03, 8'h07, 1'b0, lat, ir_low);
    checks++;
    if (z8 !== 16'h0015 || lat != 4) begin
      errors++;
      $display("FAIL midrst_next_op: got z=%h lat=%0d required z=0015 lat=4", z8, lat);
    end
    pop8();
  endtask

  task automatic test_width16();
    int lat;
    logic [15:0] a, b;
    logic [31:0] exp_u;
    logic signed [31:0] exp_s;
    int bad;
    launch16(16'hFFFF, 16'hFFFF, 1'b0, lat);
    checks++;
    if (z16 !== 32'hFFFE0001 || lat != 4) begin
      errors++;
      $display("FAIL w16_unsigned_max: got z=%h lat=%0d required z=fffe0001 lat=4", z16, lat);
    end
    pop16();
    launch16(16'h8000, 16'h7FFF, 1'b1, lat);
    checks++;
    if (z16 !== 32'hC0008000 || lat != 4) begin
      errors++;
      $display("FAIL w16_signed_edge: got z=%h lat=%0d required z=c0008000 lat=4", z16, lat);
    end
    pop16();
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      exp_u = 32'(a) * 32'(b);
      exp_s = $signed(a) * $signed(b);
      launch16(a, b, 1'b0, lat);
      checks++;
      if (z16 !== exp_u || lat != 4) begin
        errors++;
        if (bad < 5)
          $display("FAIL w16_rand_u: %h*%h got z=%h lat=%0d required z=%h lat=4", a, b, z16, lat, exp_u);
        bad++;
      end
      pop16();
      launch16(a, b, 1'b1, lat);
      checks++;
      if (z16 !== 32'(exp_s) || lat != 4) begin
        errors++;
        if (bad < 5)
          $display("FAIL w16_rand_s: %h*%h got z=%h lat=%0d required z=%h lat=4", a, b, z16, lat, exp_s);
        bad++;
      end
      pop16();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    iv8 = 1'b0; sm8 = 1'b0; or8 = 1'b0; x8 = '0; y8 = '0;
    iv16 = 1'b0; sm16 = 1'b0; or16 = 1'b0; x16 = '0; y16 = '0;
    test_reset();
    test_unsigned8();
    test_signed8();
    test_backpressure();
    test_reset_mid_op();
    test_width16();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
